// File: rtl/ram_block_256x8_pkg.sv
// rtl/ram_block_256x8_pkg.sv - shared constants and types for the self-clearing byte RAM
//
// Purpose: default geometry, the clear-controller state type and the default depth.
// Ports:   none (package).
package ram_block_256x8_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEPTH              = 2 ** DEFAULT_ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/ram_block_256x8_if.sv
// rtl/ram_block_256x8_if.sv - access bus between a client and the self-clearing byte RAM
//
// Purpose: groups the address/data/write-enable request and the read-data/ready response.
// Signals: address, data_in, write_enable (client -> RAM); data_out, ready (RAM -> client).
// Modports: master (client side), slave (RAM side).
interface ram_block_256x8_if
    import ram_block_256x8_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  ready;

    modport master (
        output address,
        output data_in,
        output write_enable,
        input  data_out,
        input  ready
    );

    modport slave (
        input  address,
        input  data_in,
        input  write_enable,
        output data_out,
        output ready
    );

endinterface

// File: rtl/ram_block_256x8_ram_array.sv
// rtl/ram_block_256x8_ram_array.sv - plain single-port synchronous storage array
//
// Purpose: one write port and one registered read port sharing an address; no reset so
//          the array maps onto block RAM. Reads are read-first (old data on a write edge).
// Ports:   clk; addr; wdata; we; rdata (registered, valid one cycle after addr).
module ram_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int WORDS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ram_block_256x8.sv
// rtl/ram_block_256x8.sv - self-clearing single-port byte RAM (UART send buffer)
//
// Purpose: after reset, sweeps every location to zero (one per cycle), then raises ready
//          and serves registered, read-first accesses on the shared address.
// Ports:   clk; reset (async, active-high); bus (slave modport: address, data_in,
//          write_enable in; data_out, ready out).
module ram_block_256x8
    import ram_block_256x8_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    ram_block_256x8_if.slave   bus
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] clear_ptr;
    logic                  ready_q;
    // Set only on edges taken in RUN, so the array's read register is known to hold a
    // real read before it is allowed onto data_out (the edge that leaves CLEAR reads
    // stale contents).
    logic                  rd_valid;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // During the sweep the clear pointer owns the array and client inputs are ignored.
    always_comb begin
        mem_addr  = bus.address;
        mem_wdata = bus.data_in;
        mem_we    = bus.write_enable;
        if (state == CLEAR) begin
            mem_addr  = clear_ptr;
            mem_wdata = '0;
            mem_we    = 1'b1;
        end
    end

    ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram_array (
        .clk   (clk),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .we    (mem_we),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CLEAR;
            clear_ptr <= '0;
            ready_q   <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clear_ptr <= clear_ptr + ADDR_WIDTH'(1);
                    if (clear_ptr == '1) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    rd_valid <= 1'b1;
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

    // Gating by a reset register makes data_out drop to zero as soon as reset asserts.
    assign bus.data_out = rd_valid ? mem_rdata : '0;
    assign bus.ready    = ready_q;

endmodule

// File: tb/tb_ram_block_256x8.sv
// tb/tb_ram_block_256x8.sv - randomized self-checking bench for ram_block_256x8
module tb_ram_block_256x8;
    import ram_block_256x8_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [7:0] model [DEPTH];

    ram_block_256x8_if bus ();

    ram_block_256x8 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    endtask

    // Called at a negedge just after reset falls; drives junk (or a fixed write) while
    // counting rising edges until ready appears.
    task automatic sweep_and_wait(input string tag, input bit fixed_write);
        int   cnt;
        logic dout_bad;
        cnt      = 0;
        dout_bad = 1'b0;
        while (cnt < 400) begin
            if (fixed_write) begin
                bus.address      = 8'h20;
                bus.data_in      = 8'h77;
                bus.write_enable = 1'b1;
            end else begin
                bus.address      = 8'($urandom);
                bus.data_in      = 8'($urandom);
                bus.write_enable = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            @(negedge clk);
            cnt++;
            if (bus.data_out !== 8'h00) dout_bad = 1'b1;
            if (bus.ready === 1'b1) break;
        end
        bus.write_enable = 1'b0;
        check({tag, "_ready_cycles"}, cnt, DEPTH);
        check({tag, "_dout_zero_in_sweep"}, {31'd0, dout_bad}, 32'd0);
        model_clear();
    endtask

    // One access issued at a negedge; data_out is sampled at the following negedge.
    task automatic access(input logic [7:0] a, input logic [7:0] d, input logic we,
                          input string tag);
        logic [7:0] exp;
        exp              = model[a];
        bus.address      = a;
        bus.data_in      = d;
        bus.write_enable = we;
        @(posedge clk);
        @(negedge clk);
        bus.write_enable = 1'b0;
        if (we) model[a] = d;
        check(tag, {24'd0, bus.data_out}, {24'd0, exp});
    endtask

    initial begin
        logic [7:0] a;
        checks           = 0;
        errors           = 0;
        reset            = 1'b1;
        bus.address      = 8'h00;
        bus.data_in      = 8'h00;
        bus.write_enable = 1'b0;
        model_clear();

        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, bus.ready}, 32'd0);
        check("reset_dout", {24'd0, bus.data_out}, 32'd0);

        reset = 1'b0;
        sweep_and_wait("sweep1", 1'b0);
        check("ready_high", {31'd0, bus.ready}, 32'd1);

        for (int i = 0; i < DEPTH; i++) access(8'(i), 8'h00, 1'b0, "cleared_read");

        access(8'h00, 8'h43, 1'b1, "write_43");
        access(8'h00, 8'h00, 1'b0, "read_43");

        access(8'h10, 8'hAA, 1'b1, "write_aa");
        access(8'h10, 8'h55, 1'b1, "rdw_old_aa");
        access(8'h10, 8'h00, 1'b0, "read_new_55");

        access(8'hFF, 8'hFF, 1'b1, "write_top");
        access(8'h00, 8'h01, 1'b1, "write_bottom");
        access(8'hFF, 8'h00, 1'b0, "read_top");
        access(8'h00, 8'h00, 1'b0, "read_bottom");

        for (int i = 0; i < 600; i++) begin
            a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            access(a, 8'($urandom), 1'($urandom_range(0, 1)), "random");
        end

        // Reset during RUN must drop ready and data_out without waiting for a clock.
        access(8'h30, 8'h5A, 1'b1, "write_5a");
        access(8'h30, 8'h00, 1'b0, "read_5a");
        #2 reset = 1'b1;
        #1;
        check("run_reset_ready", {31'd0, bus.ready}, 32'd0);
        check("run_reset_dout", {24'd0, bus.data_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Interrupt the sweep at cycle 100 with a write held on the bus.
        bus.address      = 8'h20;
        bus.data_in      = 8'h77;
        bus.write_enable = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("mid_sweep_not_ready", {31'd0, bus.ready}, 32'd0);
        #2 reset = 1'b1;
        #1;
        check("mid_sweep_reset_ready", {31'd0, bus.ready}, 32'd0);
        check("mid_sweep_reset_dout", {24'd0, bus.data_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        sweep_and_wait("sweep2", 1'b1);

        access(8'h20, 8'h00, 1'b0, "dropped_write_20");
        access(8'h30, 8'h00, 1'b0, "recleared_30");
        access(8'h10, 8'h00, 1'b0, "recleared_10");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
